// File: rtl/score_display.sv
// score_display: converts a 14-bit score to four BCD digits (double-dabble FSM)
// and time-multiplexes them onto a 4-digit active-low seven-segment display.
// Ports: clock/reset (sync, active-high), Score/GameOver in; seg/an/busy out.
module score_display #(
  parameter int REFRESH_DIV = 50000,  // clock cycles per digit-scan step
  parameter int BLINK_TICKS = 64      // scan steps per blink half-period
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [13:0] Score,
  input  logic        GameOver,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [29:0] sr;          // {bcd[15:0], binary[13:0]}
  logic [3:0]  bit_cnt;
  logic [13:0] conv_val;    // value being converted, becomes last_score in DONE
  logic [13:0] last_score;
  logic [15:0] digits;      // {thousands, hundreds, tens, ones}

  logic [13:0] score_sat;
  logic [15:0] bcd_adj;
  logic [29:0] sr_shifted;

  assign score_sat = (Score > 14'd9999) ? 14'd9999 : Score;

  // Double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 4; i++) begin
      if (sr[14 + 4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = sr[14 + 4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = sr[14 + 4*i +: 4];
    end
    sr_shifted = {bcd_adj[14:0], sr[13:0], 1'b0};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      conv_val   <= '0;
      last_score <= '0;
      digits     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (score_sat != last_score) begin
            sr       <= {16'd0, score_sat};
            conv_val <= score_sat;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr      <= sr_shifted;
          bit_cnt <= bit_cnt + 4'd1;
          // 14th shift happens when the counter reads 13
          if (bit_cnt == 4'd13)
            state <= DONE;
        end
        DONE: begin
          digits     <= sr[29:14];
          last_score <= conv_val;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Scan / blink timing
  logic [RW-1:0] ref_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          tick;

  assign tick = (ref_cnt == RW'(REFRESH_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      ref_cnt   <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      ref_cnt <= tick ? '0 : ref_cnt + RW'(1);
      if (tick)
        idx <= idx + 2'd1;
      if (!GameOver) begin
        phase     <= 1'b0;
        blink_cnt <= '0;
      end else if (tick) begin
        if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  // Digit select, leading-zero blanking and segment decode
  logic [3:0] cur_digit;
  logic       blank3, blank2, blank1;
  logic       cur_blank;

  assign blank3 = (digits[15:12] == 4'd0);
  assign blank2 = blank3 && (digits[11:8] == 4'd0);
  assign blank1 = blank2 && (digits[7:4] == 4'd0);

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    case (idx)
      2'd0: begin cur_digit = digits[3:0];   cur_blank = 1'b0;   end
      2'd1: begin cur_digit = digits[7:4];   cur_blank = blank1; end
      2'd2: begin cur_digit = digits[11:8];  cur_blank = blank2; end
      2'd3: begin cur_digit = digits[15:12]; cur_blank = blank3; end
      default: begin cur_digit = 4'd0; cur_blank = 1'b0; end
    endcase
  end

  always_comb begin
    seg = 7'b1111111;
    if (!cur_blank) begin
      case (cur_digit)
        4'd0: seg = 7'b1000000;
        4'd1: seg = 7'b1111001;
        4'd2: seg = 7'b0100100;
        4'd3: seg = 7'b0110000;
        4'd4: seg = 7'b0011001;
        4'd5: seg = 7'b0010010;
        4'd6: seg = 7'b0000010;
        4'd7: seg = 7'b1111000;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end

  assign an = phase ? 4'b1111 : ~(4'b0001 << idx);

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed-vector bench for score_display with
// REFRESH_DIV=4, BLINK_TICKS=2; hand-written segment tables per displayed value.
// Checks reset state, conversion latency/busy width, scan patterns, blanking, blink.
module tb_score_display;

  logic        clock;
  logic        reset;
  logic [13:0] Score;
  logic        GameOver;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // edges since reset was last sampled high

  // Segment tables {thousands, hundreds, tens, ones}
  localparam logic [27:0] TZ    = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
  localparam logic [27:0] T1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
  localparam logic [27:0] T9999 = {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000};
  localparam logic [27:0] T7    = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000};
  localparam logic [27:0] T100  = {7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000};
  localparam logic [27:0] T200  = {7'b1111111, 7'b0100100, 7'b1000000, 7'b1000000};

  score_display #(.REFRESH_DIV(4), .BLINK_TICKS(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .Score    (Score),
    .GameOver (GameOver),
    .seg      (seg),
    .an       (an),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    if (reset) cyc = 0;
    else cyc++;
    #1;
  endtask

  function automatic logic [1:0] exp_idx();
    return 2'((cyc / 4) % 4);
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << exp_idx());
  endfunction

  function automatic logic [6:0] tsel(input logic [27:0] t, input logic [1:0] k);
    return t[k*7 +: 7];
  endfunction

  // Apply a score, track busy width and check display changes exactly at edge 16.
  // late_at > 0 applies late_val after that edge.
  task automatic convert(input string tag, input logic [13:0] val,
                         input logic [27:0] old_t, input logic [27:0] new_t,
                         input int late_at, input logic [13:0] late_val);
    int edge_n;
    int nb;
    Score = val;
    step();
    edge_n = 1;
    nb = busy ? 1 : 0;
    chk({tag, "_busy_e1"}, busy, 1);
    while (busy && edge_n < 40) begin
      step();
      edge_n++;
      if (busy) nb++;
      if (edge_n == 15) chk({tag, "_seg_e15_old"}, seg, tsel(old_t, exp_idx()));
      if (edge_n == late_at) Score = late_val;
    end
    chk({tag, "_busy_cycles"}, nb, 15);
    chk({tag, "_done_edge"}, edge_n, 16);
    chk({tag, "_seg_e16_new"}, seg, tsel(new_t, exp_idx()));
  endtask

  // Align to index 0 and check a full scan of 16 cycles.
  task automatic check_scan(input string tag, input logic [27:0] t);
    int n;
    n = 0;
    while ((cyc % 16) != 0 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_align_idx0"}, an, 4'b1110);
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_an"}, an, exp_an());
      chk({tag, "_seg"}, seg, tsel(t, exp_idx()));
      step();
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    Score = 14'd0;
    GameOver = 1'b0;
    step();
    step();
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_no_conv", busy, 0);
    end

    convert("c1234", 14'd1234, TZ, T1234, 0, 14'd0);
    check_scan("s1234", T1234);

    convert("c12000", 14'd12000, T1234, T9999, 0, 14'd0);
    check_scan("s9999", T9999);

    convert("c7", 14'd7, T9999, T7, 0, 14'd0);
    check_scan("s7", T7);

    // 200 arrives mid-conversion; 100 must land first, then 200 converts.
    convert("c100", 14'd100, T7, T100, 5, 14'd200);
    step();
    chk("c200_restart", busy, 1);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("c200_finish", busy, 0);
    check_scan("s200", T200);

    // Blink: 8 cycles blank, 8 cycles normal
    GameOver = 1'b1;
    n = 0;
    while (an != 4'b1111 && n < 40) begin
      step();
      n++;
    end
    chk("blink_start", an, 4'b1111);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("blink_off1", an, 4'b1111);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      chk("blink_on", an, exp_an());
    end
    for (int k = 0; k < 4; k++) begin
      step();
      chk("blink_off2", an, 4'b1111);
    end

    // Reset during the blank phase
    reset = 1'b1;
    step();
    chk("rst_blink_an", an, 4'b1110);
    chk("rst_blink_seg", seg, 7'b1000000);
    chk("rst_blink_busy", busy, 0);
    GameOver = 1'b0;
    reset = 1'b0;
    step();
    chk("post_rst_conv", busy, 1);

    // Reset mid-conversion aborts; zero score then stays idle showing 0
    step();
    step();
    reset = 1'b1;
    step();
    chk("abort_busy", busy, 0);
    Score = 14'd0;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("abort_idle", busy, 0);
    end
    check_scan("s_zero", TZ);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
